// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / parallel load) with an auto-burst engine.
// Optional feature: define SHIFT_ROTATE_EN to add the rot input (serial feedback of the outgoing bit).
module shift_reg_univ #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   localparam int              CNT_W     = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic             sl_in,
   input  logic             sr_in,
   input  logic [WIDTH-1:0] p_in,
   input  logic             burst_start,
   input  logic [CNT_W-1:0] burst_len,
   input  logic             burst_dir,
`ifdef SHIFT_ROTATE_EN
   input  logic             rot,
`endif
   output logic [WIDTH-1:0] q,
   output logic             so_l,
   output logic             so_r,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_BURST = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic [WIDTH-1:0] shl_val, shr_val;
   logic [CNT_W-1:0] len_clamped;
   logic             left_in, right_in;

   // Bits entering on a shift: either the serial inputs or, when rotating, the bit falling off the other end.
`ifdef SHIFT_ROTATE_EN
   assign left_in  = rot ? q_q[WIDTH-1] : sl_in;
   assign right_in = rot ? q_q[0]       : sr_in;
`else
   assign left_in  = sl_in;
   assign right_in = sr_in;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < WIDTH; gi++) begin : g_shift
         if (gi == 0) begin : g_lsb
            assign shl_val[gi] = left_in;
         end else begin : g_lsb_n
            assign shl_val[gi] = q_q[gi-1];
         end
         if (gi == WIDTH - 1) begin : g_msb
            assign shr_val[gi] = right_in;
         end else begin : g_msb_n
            assign shr_val[gi] = q_q[gi+1];
         end
      end
   endgenerate

   assign len_clamped = (burst_len > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : burst_len;

   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (en) begin
               if (burst_start) begin
                  cnt_d = len_clamped;
                  dir_d = burst_dir;
                  if (len_clamped != '0) begin
                     state_d = S_BURST;
                     busy_d  = 1'b1;
                  end else begin
                     done_d = 1'b1;
                  end
               end else begin
                  unique case (mode)
                     2'b01:   q_d = shr_val;
                     2'b10:   q_d = shl_val;
                     2'b11:   q_d = p_in;
                     default: q_d = q_q;
                  endcase
               end
            end
         end
         S_BURST: begin
            if (en) begin
               q_d   = dir_q ? shl_val : shr_val;
               cnt_d = cnt_q - CNT_W'(1);
               // Last shift of the burst: leave BURST on the same edge.
               if (cnt_q == CNT_W'(1)) begin
                  state_d = S_IDLE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         q_q     <= RESET_VAL;
         cnt_q   <= '0;
         dir_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign q    = q_q;
   assign so_l = q_q[WIDTH-1];
   assign so_r = q_q[0];
   assign busy = busy_q;
   assign done = done_q;

endmodule
